// File: rtl/blockram_access_controller_pkg.sv
// Shared definitions for the block-RAM access controller: controller state
// encoding and response FIFO depth.
package blockram_access_controller_pkg;

    typedef enum logic {
        StInit = 1'b0,
        StRun  = 1'b1
    } ctrl_state_e;

    localparam int unsigned RESP_FIFO_DEPTH = 2;

endpackage

// File: rtl/single_port_blockram.sv
// Single-port synchronous block RAM: one access per cycle, read data is
// registered and valid the cycle after the access. No reset on contents.
module single_port_blockram #(
    parameter int unsigned SINGLE_ELEMENT_SIZE_IN_BITS = 64,
    parameter int unsigned NUMBER_SETS                 = 64,
    parameter int unsigned SET_PTR_WIDTH_IN_BITS       = $clog2(NUMBER_SETS)
) (
    input  logic                                   clk_i,
    input  logic                                   access_en_i,
    input  logic                                   write_en_i,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       addr_i,
    input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] wdata_i,
    output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] rdata_o
);

    logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] mem_q [NUMBER_SETS];

    always_ff @(posedge clk_i) begin
        if (access_en_i) begin
            if (write_en_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_o <= mem_q[addr_i];
            end
        end
    end

endmodule

// File: rtl/blockram_access_controller.sv
// Valid/ready front end for a single-port block RAM with a 2-entry response FIFO.
// Define BLOCKRAM_CTRL_INIT_EN to zero-fill the RAM after every reset.
module blockram_access_controller
    import blockram_access_controller_pkg::*;
#(
    parameter int unsigned SINGLE_ELEMENT_SIZE_IN_BITS = 64,
    parameter int unsigned NUMBER_SETS                 = 64,
    parameter int unsigned SET_PTR_WIDTH_IN_BITS       = $clog2(NUMBER_SETS)
) (
    input  logic                                   clk_in,
    input  logic                                   reset_n_in,
    input  logic                                   request_valid_in,
    output logic                                   request_ready_out,
    input  logic                                   request_write_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       request_addr_in,
    input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] request_data_in,
    output logic                                   response_valid_out,
    input  logic                                   response_ready_in,
    output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] response_data_out,
    output logic                                   init_done_out
);

    localparam int unsigned PtrW = $clog2(RESP_FIFO_DEPTH);

    ctrl_state_e state_q;

    logic                                   ram_access_en;
    logic                                   ram_write_en;
    logic [SET_PTR_WIDTH_IN_BITS-1:0]       ram_addr;
    logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] ram_wdata;
    logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] ram_rdata;

    logic                                   rd_inflight_q;
    logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] fifo_mem_q [RESP_FIFO_DEPTH];
    logic [PtrW-1:0]                        wr_ptr_q;
    logic [PtrW-1:0]                        rd_ptr_q;
    logic [PtrW:0]                          count_q;

    logic           push;
    logic           pop;
    logic [PtrW+1:0] pending;
    logic           read_room;
    logic           req_fire;

`ifdef BLOCKRAM_CTRL_INIT_EN
    localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] LastAddr =
        SET_PTR_WIDTH_IN_BITS'(NUMBER_SETS - 1);
    logic [SET_PTR_WIDTH_IN_BITS-1:0] init_addr_q;
`endif

    assign push               = rd_inflight_q;
    assign pop                = response_valid_out & response_ready_in;
    assign response_valid_out = (count_q != '0);
    assign response_data_out  = fifo_mem_q[rd_ptr_q];

    // Reads already committed to the FIFO (stored or returning from RAM) must leave a free slot.
    assign pending   = {1'b0, count_q} + {{(PtrW+1){1'b0}}, rd_inflight_q}
                     - {{(PtrW+1){1'b0}}, pop};
    assign read_room = (pending < (PtrW+2)'(RESP_FIFO_DEPTH));

    assign request_ready_out = (state_q == StRun) && (request_write_in || read_room);
    assign req_fire          = request_valid_in & request_ready_out;

    always_comb begin
        ram_access_en = req_fire;
        ram_write_en  = request_write_in;
        ram_addr      = request_addr_in;
        ram_wdata     = request_data_in;
`ifdef BLOCKRAM_CTRL_INIT_EN
        if (state_q == StInit) begin
            ram_access_en = 1'b1;
            ram_write_en  = 1'b1;
            ram_addr      = init_addr_q;
            ram_wdata     = '0;
        end
`endif
    end

    single_port_blockram #(
        .SINGLE_ELEMENT_SIZE_IN_BITS (SINGLE_ELEMENT_SIZE_IN_BITS),
        .NUMBER_SETS                 (NUMBER_SETS),
        .SET_PTR_WIDTH_IN_BITS       (SET_PTR_WIDTH_IN_BITS)
    ) u_ram (
        .clk_i       (clk_in),
        .access_en_i (ram_access_en),
        .write_en_i  (ram_write_en),
        .addr_i      (ram_addr),
        .wdata_i     (ram_wdata),
        .rdata_o     (ram_rdata)
    );

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q       <= StInit;
            init_done_out <= 1'b0;
`ifdef BLOCKRAM_CTRL_INIT_EN
            init_addr_q   <= '0;
`endif
        end else begin
            unique case (state_q)
                StInit: begin
`ifdef BLOCKRAM_CTRL_INIT_EN
                    if (init_addr_q == LastAddr) begin
                        state_q       <= StRun;
                        init_done_out <= 1'b1;
                    end else begin
                        init_addr_q <= init_addr_q + 1'b1;
                    end
`else
                    state_q       <= StRun;
                    init_done_out <= 1'b1;
`endif
                end
                StRun: begin
                    state_q       <= StRun;
                    init_done_out <= 1'b1;
                end
                default: begin
                    state_q       <= StInit;
                    init_done_out <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            rd_inflight_q <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < RESP_FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else begin
            rd_inflight_q <= req_fire & ~request_write_in;
            if (push) begin
                fifo_mem_q[wr_ptr_q] <= ram_rdata;
                wr_ptr_q             <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_blockram_access_controller.sv
// Self-checking bench for blockram_access_controller: directed vector table,
// back-pressure / streaming / reset sequences and random traffic vs. a queue model.
module tb_blockram_access_controller;

    localparam int unsigned W  = 64;
    localparam int unsigned N  = 64;
    localparam int unsigned AW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [W-1:0]  req_data;
    logic          resp_valid;
    logic          resp_ready;
    logic [W-1:0]  resp_data;
    logic          init_done;

    always #5 clk = ~clk;

    blockram_access_controller #(
        .SINGLE_ELEMENT_SIZE_IN_BITS (W),
        .NUMBER_SETS                 (N),
        .SET_PTR_WIDTH_IN_BITS       (AW)
    ) dut (
        .clk_in             (clk),
        .reset_n_in         (rst_n),
        .request_valid_in   (req_valid),
        .request_ready_out  (req_ready),
        .request_write_in   (req_write),
        .request_addr_in    (req_addr),
        .request_data_in    (req_data),
        .response_valid_out (resp_valid),
        .response_ready_in  (resp_ready),
        .response_data_out  (resp_data),
        .init_done_out      (init_done)
    );

    typedef struct {
        logic [W-1:0] data;
        int           due;
    } resp_t;

    typedef struct {
        logic          vld;
        logic          wr;
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
        logic          rr;
        logic          exp_ready;
        logic          exp_valid;
        logic [W-1:0]  exp_data;
    } vec_t;

    int           n_checks = 0;
    int           n_errors = 0;
    int           cyc = 0;
    int           outstanding = 0;
    int           accepted = 0;
    int           responses = 0;
    resp_t        exp_q[$];
    logic [W-1:0] model_mem [N];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic [AW-1:0] a,
                         input logic [W-1:0] d, input logic rr);
        req_valid  = v;
        req_write  = w;
        req_addr   = a;
        req_data   = d;
        resp_ready = rr;
        #1;
    endtask

    // Model: a read accepted in cycle c is visible at the head of the response
    // queue from cycle c+2; reads are admitted only while fewer than two are owed.
    task automatic advance();
        logic  pop;
        logic  exp_valid;
        logic  exp_rdy;
        resp_t r;
        pop       = resp_valid & resp_ready;
        exp_valid = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
        chk("resp_valid", W'(resp_valid), W'(exp_valid));
        if (resp_valid && exp_valid) chk("resp_data", resp_data, exp_q[0].data);
        exp_rdy = req_write ? 1'b1 : ((outstanding - int'(pop)) < 2);
        chk("req_ready", W'(req_ready), W'(exp_rdy));
        if (pop && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            outstanding--;
            responses++;
        end
        if (req_valid && req_ready) begin
            accepted++;
            if (req_write) begin
                model_mem[req_addr] = req_data;
            end else begin
                r.data = model_mem[req_addr];
                r.due  = cyc + 2;
                exp_q.push_back(r);
                outstanding++;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic wait_init(output int cnt);
        cnt = 0;
        while (!init_done && cnt < 200) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic apply_reset();
        exp_q.delete();
        outstanding = 0;
`ifdef BLOCKRAM_CTRL_INIT_EN
        for (int i = 0; i < N; i++) model_mem[i] = '0;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t          vecs[8];
        int            cnt;
        int            idx;
        int            a0;
        int            r0;
        logic [AW-1:0] bp_addr[4];
        logic          fire;

        vecs[0] = '{1'b1, 1'b1, 6'd63, 64'hFFFF_FFFF_0000_0000, 1'b1, 1'b1, 1'b0, 64'h0};
        vecs[1] = '{1'b1, 1'b0, 6'd63, 64'h0, 1'b1, 1'b1, 1'b0, 64'h0};
        vecs[2] = '{1'b0, 1'b0, 6'd0,  64'h0, 1'b1, 1'b1, 1'b0, 64'h0};
        vecs[3] = '{1'b1, 1'b1, 6'd5,  64'hA, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_0000_0000};
        vecs[4] = '{1'b1, 1'b0, 6'd5,  64'h0, 1'b1, 1'b1, 1'b0, 64'h0};
        vecs[5] = '{1'b0, 1'b0, 6'd0,  64'h0, 1'b1, 1'b1, 1'b0, 64'h0};
        vecs[6] = '{1'b0, 1'b0, 6'd0,  64'h0, 1'b1, 1'b1, 1'b1, 64'hA};
        vecs[7] = '{1'b0, 1'b0, 6'd0,  64'h0, 1'b1, 1'b1, 1'b0, 64'h0};
        bp_addr[0] = 6'd10;
        bp_addr[1] = 6'd20;
        bp_addr[2] = 6'd30;
        bp_addr[3] = 6'd40;

        rst_n = 1'b0;
        drive(1'b1, 1'b0, '0, '0, 1'b1);
        #1;
        chk("rst_req_ready", W'(req_ready), '0);
        chk("rst_resp_valid", W'(resp_valid), '0);
        chk("rst_resp_data", resp_data, '0);
        chk("rst_init_done", W'(init_done), '0);
        apply_reset();
        repeat (2) @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        rst_n = 1'b1;
        wait_init(cnt);
`ifdef BLOCKRAM_CTRL_INIT_EN
        chk("init_cycles", W'(cnt), W'(N));
        drive(1'b1, 1'b0, 6'd63, '0, 1'b1);
        advance();
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        advance();
        chk("init_zero_valid", W'(resp_valid), 64'h1);
        chk("init_zero_data", resp_data, 64'h0);
        advance();
`else
        chk("init_cycles", W'(cnt), 64'd1);
`endif

        // Give every address a known value.
        for (int a = 0; a < N; a++) begin
            drive(1'b1, 1'b1, AW'(a), {$urandom, $urandom}, 1'b1);
            advance();
        end

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].vld, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].rr);
            chk($sformatf("vec%0d_ready", i), W'(req_ready), W'(vecs[i].exp_ready));
            chk($sformatf("vec%0d_valid", i), W'(resp_valid), W'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) chk($sformatf("vec%0d_data", i), resp_data, vecs[i].exp_data);
            advance();
        end

        // Back-pressure: only two reads may be owed while the consumer stalls.
        idx = 0;
        r0  = responses;
        for (int s = 0; s < 6; s++) begin
            drive(1'b1, 1'b0, bp_addr[idx], '0, 1'b0);
            fire = req_ready;
            advance();
            if (fire) idx++;
        end
        chk("bp_accepted", W'(idx), 64'd2);
        for (int s = 0; s < 20 && idx < 4; s++) begin
            drive(1'b1, 1'b0, bp_addr[idx], '0, 1'b1);
            fire = req_ready;
            advance();
            if (fire) idx++;
        end
        chk("bp_all_accepted", W'(idx), 64'd4);
        for (int s = 0; s < 6; s++) begin
            drive(1'b0, 1'b0, '0, '0, 1'b1);
            advance();
        end
        chk("bp_responses", W'(responses - r0), 64'd4);

        // Streaming: one read accepted and one response per cycle.
        a0 = accepted;
        r0 = responses;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, AW'(i), '0, 1'b1);
            advance();
        end
        chk("stream_accepted", W'(accepted - a0), 64'd16);
        chk("stream_resp_in_flight", W'(responses - r0), 64'd14);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, '0, '0, 1'b1);
            advance();
        end
        chk("stream_responses", W'(responses - r0), 64'd16);

        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, $urandom % 2, AW'($urandom % N),
                  {$urandom, $urandom}, ($urandom % 4) != 0);
            advance();
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, '0, '0, 1'b1);
            advance();
        end
        chk("random_drained", W'(exp_q.size()), 64'd0);

        // Reset with one response queued and one read in flight.
        drive(1'b1, 1'b0, 6'd7, '0, 1'b0);
        advance();
        drive(1'b1, 1'b0, 6'd8, '0, 1'b0);
        advance();
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", W'(resp_valid), '0);
        chk("midrst_ready", W'(req_ready), '0);
        chk("midrst_data", resp_data, '0);
        apply_reset();
        @(negedge clk);
        rst_n = 1'b1;
        wait_init(cnt);
        chk("midrst_init_done", W'(init_done), 64'h1);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, '0, '0, 1'b1);
            advance();
        end
        drive(1'b1, 1'b0, 6'd5, '0, 1'b1);
        advance();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, '0, '0, 1'b1);
            advance();
        end
        chk("post_rst_drained", W'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/blockram_access_controller.md
BLOCKRAM_ACCESS_CONTROLLER -- requirements
Module: blockram_access_controller

Interface
REQ-001 SHALL have parameter SINGLE_ELEMENT_SIZE_IN_BITS, default 64, the data width of one RAM element.
REQ-002 SHALL have parameter NUMBER_SETS, default 64, the RAM depth in elements.
REQ-003 SHALL have parameter SET_PTR_WIDTH_IN_BITS, default $clog2(NUMBER_SETS), the address width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk_in  input  1  clock; all state changes on the rising edge.
REQ-006 reset_n_in  input  1  asynchronous active-low reset.
REQ-007 request_valid_in  input  1  a request is presented.
REQ-008 request_ready_out  output  1  the request is accepted this cycle.
REQ-009 request_write_in  input  1  1 = write, 0 = read.
REQ-010 request_addr_in  input  SET_PTR_WIDTH_IN_BITS  element address.
REQ-011 request_data_in  input  SINGLE_ELEMENT_SIZE_IN_BITS  write data.
REQ-012 response_valid_out  output  1  read data is available.
REQ-013 response_ready_in  input  1  the consumer takes the response this cycle.
REQ-014 response_data_out  output  SINGLE_ELEMENT_SIZE_IN_BITS  read data.
REQ-015 init_done_out  output  1  the controller is in state RUN.

Function
REQ-016 A request SHALL transfer only on a cycle where request_valid_in and request_ready_out are both 1.
REQ-017 A transferred request SHALL drive the RAM in the same cycle: access_en = 1, write_en = request_write_in, with the request address and data.
REQ-018 Read data SHALL return from the RAM one cycle after access and SHALL be pushed into a 2-entry response FIFO.
REQ-019 request_ready_out SHALL be 1 in RUN for writes, unconditionally.
REQ-020 request_ready_out SHALL be 1 in RUN for reads only when (FIFO occupancy + reads in flight − pops this cycle) < 2, so no read is ever dropped.
REQ-021 request_ready_out SHALL be 0 outside RUN.
REQ-022 With response_ready_in held at 1, back-to-back reads SHALL sustain one per cycle, with 2-cycle request-to-response_valid_out latency.
REQ-023 Responses SHALL be returned in request order.
REQ-024 response_data_out SHALL be stable while response_valid_out = 1 and response_ready_in = 0.
REQ-025 FIFO push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-026 A read to an address written in the previous cycle SHALL return the new data.
REQ-027 The state machine SHALL have states INIT and RUN; INIT moves to RUN after the last address is cleared (see REQ-033), and RUN is terminal until reset.

Reset
REQ-028 While reset_n_in = 0: request_ready_out = 0, response_valid_out = 0, response_data_out = 0, init_done_out = 0; FIFO emptied; reads in flight discarded.
REQ-029 Reset asserted mid-operation SHALL abort all pending reads; RAM contents SHALL be left unchanged unless BLOCKRAM_CTRL_INIT_EN is defined.
REQ-030 On release of reset, the controller SHALL enter INIT.

Configuration
REQ-031 The macro BLOCKRAM_CTRL_INIT_EN SHALL select the post-reset zero-fill.
REQ-032 With the macro defined, INIT SHALL take exactly NUMBER_SETS cycles.
REQ-033 In each INIT cycle the controller SHALL write 0 to addresses 0..NUMBER_SETS−1 in order, then move to RUN.
REQ-034 Without the macro, INIT SHALL last one cycle and perform no RAM access.

Structure
REQ-035 A shared package SHALL hold the state encoding (INIT, RUN) and the response-FIFO depth constant (2).
REQ-036 The block SHALL instantiate exactly one sub-module, single_port_blockram, with the same three parameters.

Verification
REQ-037 Write 0xFFFFFFFF00000000 to addr 63, then read addr 63 -> response_data_out = 0xFFFFFFFF00000000, 2 cycles after the read is accepted.
REQ-038 Write addr 5 = 0xA in cycle N, read addr 5 in cycle N+1 -> response 0xA.
REQ-039 Issue 4 reads with response_ready_in = 0 -> only 2 accepted; after release, 4 responses arrive in request order with no loss.
REQ-040 Issue 16 reads with response_ready_in = 1 -> one accepted per cycle and one response per cycle.
REQ-041 With BLOCKRAM_CTRL_INIT_EN defined: release reset -> init_done_out rises after 64 cycles; a read of addr 63 returns 0.
REQ-042 Assert reset with 2 reads in flight -> response_valid_out = 0 immediately; no stale response appears after reset release.
